// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end for the bit-serial complementer: takes one word per
// valid/ready handshake, pulses sclr, then shifts the word out LSB-first.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | din_ready high, waiting for a transfer
// S_CLR   | sclr visible downstream; word captured in shreg
// S_SHIFT | one word bit per cycle; cnt tracks the bit index on sbit
// S_GAP   | optional idle cycles before din_ready re-asserts
module serial_word_feeder #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sbit,
  output logic             sbit_vld,
  output logic             sfirst,
  output logic             slast,
  output logic             sclr
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] CNT_LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PRELAST = CW'(WIDTH - 2);
  localparam logic [GW-1:0] GAP_LOAD    = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_SHIFT, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             rdy_d, sbit_d, vld_d, first_d, last_d, clr_d;

  always_ff @(posedge t_clk or negedge r) begin
    if (!r) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      din_ready <= 1'b0;
      sbit      <= 1'b0;
      sbit_vld  <= 1'b0;
      sfirst    <= 1'b0;
      slast     <= 1'b0;
      sclr      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      din_ready <= rdy_d;
      sbit      <= sbit_d;
      sbit_vld  <= vld_d;
      sfirst    <= first_d;
      slast     <= last_d;
      sclr      <= clr_d;
    end
  end

  // Next-state logic also produces the next value of every output register,
  // so outputs never depend combinationally on din/din_valid.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    rdy_d   = 1'b0;
    sbit_d  = 1'b0;
    vld_d   = 1'b0;
    first_d = 1'b0;
    last_d  = 1'b0;
    clr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (din_ready && din_valid) begin
          shreg_d = din;
          cnt_d   = '0;
          clr_d   = 1'b1;
          state_d = S_CLR;
        end else begin
          rdy_d = 1'b1;
        end
      end
      S_CLR: begin
        cnt_d   = '0;
        sbit_d  = shreg_q[0];
        shreg_d = shreg_q >> 1;
        vld_d   = 1'b1;
        first_d = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          shreg_d = '0;
          cnt_d   = '0;
          if (GAP > 0) begin
            gap_d   = GAP_LOAD;
            state_d = S_GAP;
          end else begin
            rdy_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d   = cnt_q + 1'b1;
          sbit_d  = shreg_q[0];
          shreg_d = shreg_q >> 1;
          vld_d   = 1'b1;
          last_d  = (cnt_q == CNT_PRELAST);
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboard bench for serial_word_feeder: stimulus pushes expected bits and
// complementer results; a negedge monitor pops and compares.
module tb_serial_word_feeder;

  logic       t_clk = 1'b0;
  logic       r;
  logic [7:0] din, din1;
  logic       din_valid, din_valid1;
  logic       din_ready, sbit, sbit_vld, sfirst, slast, sclr;
  logic       din_ready1, sbit1, sbit_vld1, sfirst1, slast1, sclr1;

  always #5 t_clk = ~t_clk;

  serial_word_feeder #(.WIDTH(8), .GAP(0)) dut0 (
    .t_clk(t_clk), .r(r), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .sbit(sbit), .sbit_vld(sbit_vld), .sfirst(sfirst), .slast(slast), .sclr(sclr)
  );

  serial_word_feeder #(.WIDTH(8), .GAP(2)) dut1 (
    .t_clk(t_clk), .r(r), .din(din1), .din_valid(din_valid1), .din_ready(din_ready1),
    .sbit(sbit1), .sbit_vld(sbit_vld1), .sfirst(sfirst1), .slast(slast1), .sclr(sclr1)
  );

  typedef struct packed {logic b; logic f; logic l;} exp_t;
  exp_t       exp_q[$];
  logic [7:0] comp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_sclr = -1;
  int sclr_gap = -1;
  int midx = 0;
  logic seen = 1'b0;
  logic [7:0] acc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compares every presented bit and models the downstream complementer.
  always @(negedge t_clk) begin
    exp_t e;
    cyc++;
    if (!r) begin
      seen = 1'b0;
      midx = 0;
      last_sclr = -1;
    end else begin
      if (sclr) begin
        if (last_sclr >= 0) sclr_gap = cyc - last_sclr;
        last_sclr = cyc;
        seen = 1'b0;
        midx = 0;
        check("sclr_with_vld", {31'd0, sbit_vld}, 32'd0);
      end
      if (sbit_vld) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bit actual=%0b required=none", sbit);
        end else begin
          e = exp_q.pop_front();
          check("bit", {29'd0, sbit, sfirst, slast}, {29'd0, e.b, e.f, e.l});
          if (midx < 8) acc[midx] = sbit ^ seen;
          seen = seen | sbit;
          midx++;
          if (slast && comp_q.size() > 0) check("complement", {24'd0, acc}, {24'd0, comp_q.pop_front()});
        end
      end else begin
        check("idle_zero", {29'd0, sbit, sfirst, slast}, 32'd0);
      end
    end
  end

  task automatic send(input logic [7:0] w, input logic [7:0] c);
    logic rdy;
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back('{b: w[i], f: (i == 0), l: (i == 7)});
    comp_q.push_back(c);
    din = w;
    din_valid = 1'b1;
    do begin
      rdy = din_ready;
      @(posedge t_clk);
      #1;
      n++;
    end while (!rdy && n < 40);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not_ready required=ready");
    end
    din_valid = 1'b0;
    din = ~w;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge t_clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
      exp_q.delete();
      comp_q.delete();
    end
    repeat (2) @(posedge t_clk);
    #1;
  endtask

  initial begin
    logic [7:0] w1;
    int k, after;
    logic got_last, gap_vld;

    r = 1'b0;
    din = 8'h5A;
    din_valid = 1'b1;
    din1 = 8'h00;
    din_valid1 = 1'b0;
    repeat (4) @(posedge t_clk);
    #1;
    check("reset_outputs", {23'd0, din_ready, sbit, sbit_vld, sfirst, slast, sclr,
                            din_ready1, sbit_vld1, sclr1}, 32'd0);
    din_valid = 1'b0;
    r = 1'b1;
    @(posedge t_clk);
    #1;
    check("ready_after_reset", {31'd0, din_ready}, 32'd1);

    // Single word: B4 -> bits 0,0,1,0,1,1,0,1; complement 4C
    send(8'hB4, 8'h4C);
    drain();

    // Back-to-back with din_valid held high
    send(8'h01, 8'hFF);
    send(8'h80, 8'h80);
    drain();
    check("sclr_period", sclr_gap, 32'd10);

    // Busy ignore: din/din_valid wiggle while shifting
    send(8'hA5, 8'h5B);
    repeat (2) @(posedge t_clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      din = 8'h3C ^ 8'(i * 8'h11);
      din_valid = i[0];
      @(posedge t_clk);
      #1;
    end
    din_valid = 1'b0;
    drain();
    repeat (12) @(posedge t_clk);
    #1;
    check("idle_after_busy", {31'd0, din_ready}, 32'd1);

    // Reset mid-word after bit 3 is on the wire
    send(8'hC3, 8'h3D);
    repeat (4) @(posedge t_clk);
    @(negedge t_clk);
    #1;
    r = 1'b0;
    #1;
    check("reset_midword", {28'd0, sbit_vld, slast, sclr, din_ready}, 32'd0);
    exp_q.delete();
    comp_q.delete();
    repeat (2) @(posedge t_clk);
    #1;
    r = 1'b1;
    send(8'hFF, 8'h01);
    drain();

    // GAP=2 instance: din_ready returns 3 cycles after slast
    din1 = 8'h0F;
    din_valid1 = 1'b1;
    @(posedge t_clk);
    #1;
    din_valid1 = 1'b0;
    din1 = 8'hAA;
    w1 = '0;
    k = 0;
    after = 0;
    got_last = 1'b0;
    gap_vld = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge t_clk);
      #1;
      if (sbit_vld1 && k < 8) begin
        w1[k] = sbit1;
        k++;
      end
      if (got_last) begin
        after++;
        if (sbit_vld1) gap_vld = 1'b1;
        if (din_ready1) break;
      end
      if (slast1) got_last = 1'b1;
    end
    check("gap_word", {24'd0, w1}, 32'h0F);
    check("gap_ready_delay", after, 32'd3);
    check("gap_vld_quiet", {30'd0, got_last, gap_vld}, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
